// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two combinational read ports,
// optional write-to-read bypass and hardwired-zero R0, plus a busy scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rsv_en,
  input  logic [$clog2(NUM_REGS)-1:0] rsv_addr,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_a,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]           rd_data_a,
  output logic [DATA_W-1:0]           rd_data_b,
  output logic                        busy_a,
  output logic                        busy_b,
  output logic                        hazard
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic wr_ok;
  logic rsv_ok;
  logic zero_a;
  logic zero_b;
  logic byp_a;
  logic byp_b;

  assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  // Reserve is applied after write so a same-cycle reserve leaves the entry busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

  assign zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);

  // Bypass is held off during reset and clear so reads show the stored contents.
  assign byp_a = (BYPASS != 0) && rst_n && !clr && wr_en && (wr_addr == rd_addr_a) && !zero_a;
  assign byp_b = (BYPASS != 0) && rst_n && !clr && wr_en && (wr_addr == rd_addr_b) && !zero_b;

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (zero_a)     rd_data_a = '0;
    else if (byp_a) rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (zero_b)     rd_data_b = '0;
    else if (byp_b) rd_data_b = wr_data;
  end

  assign busy_a = busy[rd_addr_a] && !zero_a && !byp_a;
  assign busy_b = busy[rd_addr_b] && !zero_b && !byp_b;
  assign hazard = busy_a || busy_b;

  logic unused_w;
  assign unused_w = (ADDR_W == 0);

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp: three configurations (bypass, no bypass,
// zero-R0) share one stimulus and are checked against an array-based model.
module tb_reg_file_mp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsv_en;
  logic [1:0] rsv_addr;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;

  logic [7:0] rda [3];
  logic [7:0] rdb [3];
  logic       ba  [3];
  logic       bb  [3];
  logic       hz  [3];

  localparam bit BYP [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit ZR  [3] = '{1'b0, 1'b0, 1'b1};

  logic [7:0] m_reg  [3][4];
  bit         m_busy [3][4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .busy_a(ba[0]), .busy_b(bb[0]), .hazard(hz[0]));

  reg_file_mp #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .busy_a(ba[1]), .busy_b(bb[1]), .hazard(hz[1]));

  reg_file_mp #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda[2]), .rd_data_b(rdb[2]), .busy_a(ba[2]), .busy_b(bb[2]), .hazard(hz[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        m_reg[k][i]  = 8'h00;
        m_busy[k][i] = 1'b0;
      end
  endfunction

  // Visible value of register a in configuration k given the current inputs.
  function automatic logic [7:0] exp_rd(input int k, input logic [1:0] a);
    if (!rst_n) return 8'h00;
    if (ZR[k] && a == 2'd0) return 8'h00;
    if (BYP[k] && wr_en && !clr && wr_addr == a) return wr_data;
    return m_reg[k][a];
  endfunction

  function automatic bit exp_busy(input int k, input logic [1:0] a);
    if (!rst_n) return 1'b0;
    if (ZR[k] && a == 2'd0) return 1'b0;
    if (BYP[k] && wr_en && !clr && wr_addr == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic void model_edge();
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          m_reg[k][i]  = 8'h00;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (wr_en && !(ZR[k] && wr_addr == 2'd0)) begin
          m_reg[k][wr_addr]  = wr_data;
          m_busy[k][wr_addr] = 1'b0;
        end
        if (rsv_en && !(ZR[k] && rsv_addr == 2'd0)) m_busy[k][rsv_addr] = 1'b1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_rda%0d", tag, k), 32'(rda[k]), 32'(exp_rd(k, rd_addr_a)));
      check($sformatf("%s_rdb%0d", tag, k), 32'(rdb[k]), 32'(exp_rd(k, rd_addr_b)));
      check($sformatf("%s_ba%0d", tag, k), 32'(ba[k]), 32'(exp_busy(k, rd_addr_a)));
      check($sformatf("%s_bb%0d", tag, k), 32'(bb[k]), 32'(exp_busy(k, rd_addr_b)));
      check($sformatf("%s_hz%0d", tag, k), 32'(hz[k]),
            32'(exp_busy(k, rd_addr_a) | exp_busy(k, rd_addr_b)));
    end
  endtask

  task automatic drive(input bit w, input logic [1:0] wa, input logic [7:0] wd,
                       input bit r, input logic [1:0] ra,
                       input logic [1:0] a, input logic [1:0] b, input bit c);
    wr_en = w; wr_addr = wa; wr_data = wd;
    rsv_en = r; rsv_addr = ra;
    rd_addr_a = a; rd_addr_b = b; clr = c;
    #2;
  endtask

  // Finish the current cycle: clock edge, model update, back to the falling edge.
  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input string tag, input bit w, input logic [1:0] wa, input logic [7:0] wd,
                      input bit r, input logic [1:0] ra,
                      input logic [1:0] a, input logic [1:0] b, input bit c);
    drive(w, wa, wd, r, ra, a, b, c);
    check_all(tag);
    finish_cycle();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
            2'($urandom), 2'($urandom), 1'b0);
      check_all("rst");
      check("rst_hz_const", 32'(hz[0]), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i += 2) step("rst_rd", 0, 0, 0, 0, 0, 2'(i), 2'(i + 1), 0);

    step("wr1", 1, 2'd1, 8'hA5, 0, 0, 0, 0, 0);
    step("wr2", 1, 2'd2, 8'h3C, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 2'd1, 2'd2, 0);
    check("t2_a", 32'(rda[0]), 32'hA5);
    check("t2_b", 32'(rdb[0]), 32'h3C);
    check_all("rd12");
    finish_cycle();
    step("rd11", 0, 0, 0, 0, 0, 2'd1, 2'd1, 0);

    drive(1, 2'd3, 8'h5A, 0, 0, 2'd3, 2'd0, 0);
    check("t3_byp", 32'(rda[0]), 32'h5A);
    check("t3_nobyp", 32'(rda[1]), 32'h00);
    check_all("byp");
    finish_cycle();
    drive(0, 0, 0, 0, 0, 2'd3, 2'd0, 0);
    check("t3_after", 32'(rda[1]), 32'h5A);
    check_all("byp_after");
    finish_cycle();

    step("rsv2", 0, 0, 0, 1, 2'd2, 0, 2'd2, 0);
    drive(0, 0, 0, 0, 0, 2'd0, 2'd2, 0);
    check("t4_busy", 32'(bb[0]), 32'd1);
    check("t4_hz", 32'(hz[0]), 32'd1);
    check_all("busy2");
    finish_cycle();
    step("wr2b", 1, 2'd2, 8'h11, 0, 0, 0, 2'd2, 0);
    step("rd2b", 0, 0, 0, 0, 0, 0, 2'd2, 0);
    step("rsvwr2", 1, 2'd2, 8'h22, 1, 2'd2, 0, 2'd2, 0);
    drive(0, 0, 0, 0, 0, 2'd2, 2'd2, 0);
    check("t4_keep", 32'(ba[0]), 32'd1);
    check_all("rsvwr2_after");
    finish_cycle();
    step("rsv_twice", 0, 0, 0, 1, 2'd2, 2'd2, 2'd2, 0);
    step("wr_clears", 1, 2'd2, 8'h33, 0, 0, 2'd2, 2'd2, 0);
    step("after_clr2", 0, 0, 0, 0, 0, 2'd2, 2'd2, 0);

    step("z_wr0", 1, 2'd0, 8'hFF, 1, 2'd0, 2'd0, 2'd0, 0);
    drive(0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    check("t5_z_rd", 32'(rda[2]), 32'h00);
    check("t5_z_busy", 32'(ba[2]), 32'd0);
    check_all("z_rd0");
    finish_cycle();
    step("rsv3", 0, 0, 0, 1, 2'd3, 0, 0, 0);
    step("clr", 1, 2'd1, 8'h77, 1, 2'd1, 2'd1, 2'd3, 1);
    drive(0, 0, 0, 0, 0, 2'd1, 2'd3, 0);
    check("t5_clr", 32'(rda[0]), 32'h00);
    check_all("after_clr");
    finish_cycle();

    step("ar_wr1", 1, 2'd1, 8'hA5, 1, 2'd2, 2'd1, 2'd2, 0);
    drive(0, 0, 0, 0, 0, 2'd1, 2'd2, 0);
    check("t6_pre_busy", 32'(bb[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rd", 32'(rda[0]), 32'h00);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_after", 0, 0, 0, 0, 0, 2'd1, 2'd2, 0);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
           2'($urandom), 2'($urandom), ($urandom_range(15) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
